ex_mdu: RTL and testbench
=========================

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width (even, >=8).
REQ-002 Parameter DIV_BITS, default 1, quotient bits resolved per divide cycle (1 or 2); WIDTH divisible by DIV_BITS.
REQ-003 Parameter MUL_LAT, default 2, multiply latency in cycles (>=1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mdu_start  input  1  op valid in EX this cycle.
REQ-007 mdu_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-008 src_a  input  WIDTH  rs operand / dividend.
REQ-009 src_b  input  WIDTH  rt operand / divisor.
REQ-010 acc_hi  input  WIDTH  forwarded HI, used by MADD/MSUB.
REQ-011 acc_lo  input  WIDTH  forwarded LO, used by MADD/MSUB.
REQ-012 flush  input  1  exception/eret flush; abort current op.
REQ-013 mdu_stall_req  output  1  hold the pipeline front.
REQ-014 mdu_res_valid  output  1  one-cycle pulse, results final.
REQ-015 mdu_hi_res  output  WIDTH  HI result (product high / remainder).
REQ-016 mdu_lo_res  output  WIDTH  LO result (product low / quotient).
REQ-017 mdu_div_zero  output  1  valid with mdu_res_valid; divisor was zero.

Function
REQ-018 States IDLE, MUL, DIV, DONE; start accepted only in IDLE.
REQ-019 On accepted start, op, src_a, src_b, acc_hi, acc_lo latched; later input changes ignored.
REQ-020 IDLE->MUL for op 000/001/1xx; IDLE->DIV for 010/011.
REQ-021 MUL: full 2*WIDTH product, signed for even op codes, unsigned for odd; MADD adds to {acc_hi,acc_lo}, MSUB subtracts from it, mod 2^(2*WIDTH).
REQ-022 MUL: mdu_res_valid asserted exactly MUL_LAT cycles after the start cycle.
REQ-023 DIV: restoring/non-restoring iteration, DIV_BITS per cycle, WIDTH/DIV_BITS iterations plus one sign-fixup cycle; mdu_res_valid WIDTH/DIV_BITS+1 cycles after start (33 at defaults).
REQ-024 DIV signed: quotient truncates toward zero, remainder takes dividend sign; unsigned ops treat operands as unsigned.
REQ-025 Divisor zero: no iteration skip required, result hi=src_a, lo=all ones, mdu_div_zero=1; same latency as normal divide.
REQ-026 Signed overflow (most-negative / -1): lo=most-negative, hi=0, no flag.
REQ-027 mdu_stall_req = 1 combinationally in the accepted start cycle and every cycle until mdu_res_valid; 0 in the mdu_res_valid cycle so the consumer captures results.
REQ-028 DONE lasts one cycle (mdu_res_valid=1), then IDLE; a start in the DONE cycle is ignored and must be re-presented.
REQ-029 mdu_hi_res/mdu_lo_res hold last valid result until next mdu_res_valid; intermediate values never visible.
REQ-030 flush in any non-IDLE state: next state IDLE, no mdu_res_valid, mdu_stall_req 0 from the flush cycle; results unchanged.
REQ-031 flush with mdu_start in same cycle: flush wins, op not accepted.
REQ-032 mdu_start while busy: ignored, no effect on current op.

Reset
REQ-033 rst asserted: state IDLE, mdu_stall_req 0, mdu_res_valid 0, mdu_div_zero 0, mdu_hi_res 0, mdu_lo_res 0, immediately and asynchronously.
REQ-034 rst mid-operation: op discarded, no mdu_res_valid after deassertion; first start after deassertion accepted normally.

Verification
REQ-035 MULT src_a=FFFFFFFD, src_b=5, defaults -> valid at cycle+2, hi=FFFFFFFF, lo=FFFFFFF1; stall high cycles 0-1, low cycle 2.
REQ-036 DIV src_a=7, src_b=FFFFFFFE -> valid at cycle+33, lo=FFFFFFFD, hi=1; DIVU same operands -> lo=0, hi=7.
REQ-037 DIVU src_a=12345678, src_b=0 -> valid at cycle+33, hi=12345678, lo=FFFFFFFF, mdu_div_zero=1.
REQ-038 MADDU acc_hi=0, acc_lo=FFFFFFFF, src_a=1, src_b=1 -> hi=1, lo=0; MSUB acc 0:0, 1*1 -> hi=lo=FFFFFFFF.
REQ-039 DIV started, flush at cycle+10 -> no valid pulse ever, stall 0 from cycle+10, start at cycle+11 accepted and completes at cycle+44.
REQ-040 DIV_BITS=2 rebuild: DIV 100/7 -> valid at cycle+17, lo=E, hi=2; async rst at cycle+5 -> all outputs 0 same cycle, no valid.

Source files
------------

// File: rtl/ex_mdu.sv
// Multiply/divide unit for the EX stage: MULT/MULTU/MADD(U)/MSUB(U) and DIV/DIVU into HI/LO.
// Latency: multiply MUL_LAT cycles, divide WIDTH/DIV_BITS+1 cycles, counted from the start cycle.
// Backpressure: mdu_stall_req holds the pipeline front from the start cycle until the result cycle.
module ex_mdu #(
    parameter int WIDTH    = 32,
    parameter int DIV_BITS = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mdu_start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic             flush,
    output logic             mdu_stall_req,
    output logic             mdu_res_valid,
    output logic [WIDTH-1:0] mdu_hi_res,
    output logic [WIDTH-1:0] mdu_lo_res,
    output logic             mdu_div_zero
);

    localparam int DIV_ITERS = WIDTH / DIV_BITS;
    localparam int CNT_MAX   = (DIV_ITERS > MUL_LAT) ? DIV_ITERS : MUL_LAT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, acch_q, accl_q;
    logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;
    logic               negq_q, negr_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               dz_q;

    logic               accept;
    logic               wr_mul, wr_div;
    logic [2:0]         m_op;
    logic [WIDTH-1:0]   m_a, m_b, m_hi, m_lo;
    logic               m_sgn;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
    logic               d_sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     it_rem;
    logic [WIDTH-1:0]   it_quo, q_fix, r_fix;

    assign accept        = (state_q == S_IDLE) && mdu_start && !flush;
    assign mdu_res_valid = (state_q == S_DONE);
    assign mdu_stall_req = ~rst & (accept | (((state_q == S_MUL) | (state_q == S_DIV)) & ~flush));
    assign mdu_hi_res    = hi_q;
    assign mdu_lo_res    = lo_q;
    assign mdu_div_zero  = dz_q;

    // Product and accumulate; live inputs are used in IDLE so MUL_LAT=1 can finish at the start edge.
    always_comb begin
        m_op    = (state_q == S_IDLE) ? mdu_op : op_q;
        m_a     = (state_q == S_IDLE) ? src_a  : a_q;
        m_b     = (state_q == S_IDLE) ? src_b  : b_q;
        m_hi    = (state_q == S_IDLE) ? acc_hi : acch_q;
        m_lo    = (state_q == S_IDLE) ? acc_lo : accl_q;
        m_sgn   = ~m_op[0];
        ext_a   = {{WIDTH{m_sgn & m_a[WIDTH-1]}}, m_a};
        ext_b   = {{WIDTH{m_sgn & m_b[WIDTH-1]}}, m_b};
        prod    = ext_a * ext_b;
        mul_res = prod;
        if (m_op[2]) begin
            mul_res = m_op[1] ? ({m_hi, m_lo} - prod) : ({m_hi, m_lo} + prod);
        end
    end

    // Operand magnitudes for the divider; signs are reapplied when the result is written.
    always_comb begin
        d_sgn = ~mdu_op[0];
        a_neg = d_sgn & src_a[WIDTH-1];
        b_neg = d_sgn & src_b[WIDTH-1];
        a_mag = a_neg ? (~src_a + ONE) : src_a;
        b_mag = b_neg ? (~src_b + ONE) : src_b;
    end

    // DIV_BITS restoring steps per cycle, then sign fixup of the final step's outputs.
    always_comb begin
        it_rem = {1'b0, rem_q};
        it_quo = quo_q;
        for (int i = 0; i < DIV_BITS; i++) begin
            it_rem = {it_rem[WIDTH-1:0], it_quo[WIDTH-1]};
            it_quo = {it_quo[WIDTH-2:0], 1'b0};
            if (it_rem >= {1'b0, dvsr_q}) begin
                it_rem    = it_rem - {1'b0, dvsr_q};
                it_quo[0] = 1'b1;
            end
        end
        q_fix = negq_q ? (~it_quo + ONE) : it_quo;
        r_fix = negr_q ? (~it_rem[WIDTH-1:0] + ONE) : it_rem[WIDTH-1:0];
    end

    // Next-state and result-write decisions; flush drops any in-flight op back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_mul  = 1'b0;
        wr_div  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (mdu_op[2:1] == 2'b01) begin
                        state_d = S_DIV;
                        cnt_d   = CNT_W'(DIV_ITERS);
                    end else if (MUL_LAT == 1) begin
                        state_d = S_DONE;
                        wr_mul  = 1'b1;
                    end else begin
                        state_d = S_MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    wr_mul  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    wr_div  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand latches, divider datapath and architectural results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acch_q  <= '0;
            accl_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q   <= mdu_op;
                a_q    <= src_a;
                b_q    <= src_b;
                acch_q <= acc_hi;
                accl_q <= acc_lo;
                rem_q  <= '0;
                quo_q  <= a_mag;
                dvsr_q <= b_mag;
                negq_q <= a_neg ^ b_neg;
                negr_q <= a_neg;
            end else if (state_q == S_DIV && !flush) begin
                rem_q <= it_rem[WIDTH-1:0];
                quo_q <= it_quo;
            end
            if (wr_mul) begin
                hi_q <= mul_res[2*WIDTH-1:WIDTH];
                lo_q <= mul_res[WIDTH-1:0];
                dz_q <= 1'b0;
            end else if (wr_div) begin
                if (dvsr_q == '0) begin
                    hi_q <= a_q;
                    lo_q <= '1;
                    dz_q <= 1'b1;
                end else begin
                    hi_q <= r_fix;
                    lo_q <= q_fix;
                    dz_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2, start, start2, flush;
    logic [2:0]  op;
    logic [31:0] a, b, ah, al;
    logic        s1, v1, z1, s2, v2, z2;
    logic [31:0] h1, l1, h2, l2;

    ex_mdu #(.WIDTH(32), .DIV_BITS(1), .MUL_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .mdu_start(start), .mdu_op(op), .src_a(a), .src_b(b),
        .acc_hi(ah), .acc_lo(al), .flush(flush), .mdu_stall_req(s1), .mdu_res_valid(v1),
        .mdu_hi_res(h1), .mdu_lo_res(l1), .mdu_div_zero(z1));

    ex_mdu #(.WIDTH(32), .DIV_BITS(2), .MUL_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst2), .mdu_start(start2), .mdu_op(op), .src_a(a), .src_b(b),
        .acc_hi(ah), .acc_lo(al), .flush(flush), .mdu_stall_req(s2), .mdu_res_valid(v2),
        .mdu_hi_res(h2), .mdu_lo_res(l2), .mdu_div_zero(z2));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, h, l;
        logic [31:0] eh, el;
        logic        ez;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_hi [2];
    logic [31:0] last_lo [2];

    function automatic logic get_valid(input int d); return (d == 0) ? v1 : v2; endfunction
    function automatic logic get_stall(input int d); return (d == 0) ? s1 : s2; endfunction
    function automatic logic get_dz(input int d);    return (d == 0) ? z1 : z2; endfunction
    function automatic logic [31:0] get_hi(input int d); return (d == 0) ? h1 : h2; endfunction
    function automatic logic [31:0] get_lo(input int d); return (d == 0) ? l1 : l2; endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) start = v; else start2 = v;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the ISA definitions.
    function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        longint      sx, sy;
        logic [63:0] p;
        if (o[2:1] == 2'b01) begin
            if (y == 32'h0) return {1'b1, x, 32'hFFFFFFFF};
            if (o[0] == 1'b0) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return {1'b0, 32'(sx % sy), 32'(sx / sy)};
            end
            return {1'b0, x % y, x / y};
        end
        if (o[0] == 1'b0) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = 64'(sx * sy);
        end else begin
            p = {32'h0, x} * {32'h0, y};
        end
        if (o[2]) p = o[1] ? ({h, l} - p) : ({h, l} + p);
        return {1'b0, p};
    endfunction

    task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] xh, input logic [31:0] xl, input logic [31:0] eh,
                          input logic [31:0] el, input logic ez, input bit scr, input string tag);
        int lat;
        int got;
        bit st_ok;
        bit hold_ok;
        lat     = (o[2:1] == 2'b01) ? ((d == 0) ? 33 : 17) : 2;
        got     = -1;
        st_ok   = 1'b1;
        hold_ok = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; op = o; a = xa; b = xb; ah = xh; al = xl;
        set_start(d, 1'b1);
        @(negedge clk);
        if (get_stall(d) !== 1'b1 || get_valid(d) !== 1'b0) st_ok = 1'b0;
        for (int c = 1; c <= lat + 4; c++) begin
            @(posedge clk); #1;
            if (scr) begin
                op = 3'($urandom); a = $urandom; b = $urandom; ah = $urandom; al = $urandom;
                set_start(d, 1'($urandom_range(0, 1)));
            end else begin
                set_start(d, 1'b0);
            end
            @(negedge clk);
            if (get_valid(d) === 1'b1) begin
                got = c;
                check({tag, " hi"}, 64'(get_hi(d)), 64'(eh));
                check({tag, " lo"}, 64'(get_lo(d)), 64'(el));
                check({tag, " div_zero"}, 64'(get_dz(d)), 64'(ez));
                if (get_stall(d) !== 1'b0) st_ok = 1'b0;
                set_start(d, 1'b0);
                break;
            end
            if (get_stall(d) !== 1'b1) st_ok = 1'b0;
            if (get_hi(d) !== last_hi[d] || get_lo(d) !== last_lo[d]) hold_ok = 1'b0;
        end
        set_start(d, 1'b0);
        check({tag, " latency"}, 64'(got), 64'(lat));
        check({tag, " stall pattern"}, 64'(st_ok), 64'(1));
        check({tag, " results held while busy"}, 64'(hold_ok), 64'(1));
        last_hi[d] = eh;
        last_lo[d] = el;
    endtask

    task automatic watch_idle(input int d, input int n, input string tag);
        int hits;
        hits = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (get_valid(d) !== 1'b0 || get_stall(d) !== 1'b0) hits++;
        end
        check({tag, " no valid/stall"}, 64'(hits), 64'(0));
    endtask

    vec_t tbl [14];

    initial begin
        logic [64:0] m;
        logic [2:0]  ro;
        logic [31:0] ra, rb, rh, rl;
        bit          flag;

        tbl[0]  = '{3'b000, 32'hFFFFFFFD, 32'h5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        tbl[1]  = '{3'b010, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFD, 1'b0};
        tbl[2]  = '{3'b011, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h7, 32'h0, 1'b0};
        tbl[3]  = '{3'b011, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        tbl[4]  = '{3'b101, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0};
        tbl[5]  = '{3'b110, 32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[6]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h80000000, 1'b0};
        tbl[7]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h1, 1'b0};
        tbl[8]  = '{3'b010, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[9]  = '{3'b010, 32'hFFFFFFF9, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        tbl[10] = '{3'b100, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{3'b111, 32'h2, 32'h3, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFA, 1'b0};
        tbl[12] = '{3'b000, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h0, 1'b0};
        tbl[13] = '{3'b011, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0};

        rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0; flush = 1'b0;
        op = 3'b0; a = '0; b = '0; ah = '0; al = '0;
        last_hi[0] = '0; last_lo[0] = '0; last_hi[1] = '0; last_lo[1] = '0;

        // Reset state of both instances.
        #2;
        check("reset valid", 64'(v1), 64'(0));
        check("reset stall", 64'(s1), 64'(0));
        check("reset hi", 64'(h1), 64'(0));
        check("reset lo", 64'(l1), 64'(0));
        check("reset div_zero", 64'(z1), 64'(0));
        check("reset2 outputs", 64'({v2, s2, z2, h2}), 64'(0));
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        // Directed table; odd entries scramble inputs and re-assert start while busy.
        for (int i = 0; i < 14; i++) begin
            run_op(0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].h, tbl[i].l,
                   tbl[i].eh, tbl[i].el, tbl[i].ez, (i % 2) == 1, $sformatf("vec%0d", i));
        end

        // Flush ten cycles into a divide, then a new divide the next cycle.
        @(posedge clk); #1;
        op = 3'b010; a = 32'd1000; b = 32'd3; start = 1'b1;
        flag = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (get_valid(0) !== 1'b0) flag = 1'b1;
            if (c < 10 && s1 !== 1'b1) flag = 1'b1;
        end
        check("flush stall drop", 64'(s1), 64'(0));
        check("pre-flush behaviour", 64'(flag), 64'(0));
        run_op(0, 3'b011, 32'd1000, 32'd10, 32'h0, 32'h0, 32'd0, 32'd100, 1'b0, 1'b0, "after flush");

        // Flush and start together: op is not taken.
        @(posedge clk); #1;
        op = 3'b000; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush+start stall", 64'(s1), 64'(0));
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        watch_idle(0, 40, "flush+start");

        // Start presented during the DONE cycle is dropped.
        @(posedge clk); #1;
        op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        op = 3'b001; a = 32'd2; b = 32'd2; start = 1'b1;
        @(negedge clk);
        check("done-cycle valid", 64'(v1), 64'(1));
        check("done-cycle result", {h1, l1}, 64'd42);
        check("done-cycle stall", 64'(s1), 64'(0));
        @(posedge clk); #1;
        start = 1'b0;
        watch_idle(0, 10, "start in done");
        last_hi[0] = 32'h0; last_lo[0] = 32'd42;

        // Randomised operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            rh = $urandom; rl = $urandom;
            m  = model(ro, ra, rb, rh, rl);
            run_op(0, ro, ra, rb, rh, rl, m[63:32], m[31:0], m[64], 1'b1, "rnd");
        end

        // Radix-4 instance: directed divide, then asynchronous reset mid-divide.
        run_op(1, 3'b010, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'hE, 1'b0, 1'b0, "r4 div");
        @(posedge clk); #1;
        op = 3'b010; a = 32'd1000; b = 32'd7; start2 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
        end
        rst2 = 1'b1;
        #1;
        check("async rst valid", 64'(v2), 64'(0));
        check("async rst stall", 64'(s2), 64'(0));
        check("async rst hi/lo", {h2, l2}, 64'(0));
        check("async rst div_zero", 64'(z2), 64'(0));
        @(negedge clk);
        rst2 = 1'b0;
        last_hi[1] = '0; last_lo[1] = '0;
        watch_idle(1, 25, "post reset");
        run_op(1, 3'b011, 32'd1000, 32'd7, 32'h0, 32'h0, 32'd6, 32'd142, 1'b0, 1'b0, "r4 after rst");
        for (int i = 0; i < 15; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(1, 1000));
            rh = $urandom; rl = $urandom;
            m  = model(ro, ra, rb, rh, rl);
            run_op(1, ro, ra, rb, rh, rl, m[63:32], m[31:0], m[64], 1'b1, "r4 rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
